// File: rtl/jam_cost_loader_pkg.sv
// jam_pkg: shared types and sizes for the JAM cost-matrix loader.
// Used by jam_cost_loader, its stream interface and jam_cost_bank.
package jam_pkg;

  localparam int N      = 8;
  localparam int COST_W = 7;
  localparam int IDX_W  = 3;
  localparam int ENT_W  = 6;

  localparam logic [ENT_W-1:0] LAST_ENT = 6'd63;

  typedef logic [COST_W-1:0] cost_t;

  typedef enum logic {
    LOAD,
    SERVE
  } ld_state_e;

  function automatic logic [ENT_W-1:0] ent_addr(
    input logic [IDX_W-1:0] w,
    input logic [IDX_W-1:0] j
  );
    return {w, j};
  endfunction

endpackage

// File: rtl/jam_cost_loader_if.sv
// jam_cost_loader_if: valid/ready stream of cost entries into the loader.
// master = upstream producer, slave = jam_cost_loader.
interface jam_cost_loader_if;
  import jam_pkg::*;

  logic  in_valid;
  logic  in_ready;
  cost_t in_data;
  logic  in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/jam_cost_loader_bank.sv
// jam_cost_bank: 8x8 cost table, synchronous write and clear,
// combinational (W,J) read.
module jam_cost_bank
  import jam_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ENT_W-1:0] waddr,
  input  cost_t            wdata,
  input  logic [IDX_W-1:0] W,
  input  logic [IDX_W-1:0] J,
  output cost_t            rdata
);

  cost_t r_mem [N*N];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N*N; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[ent_addr(W, J)];

endmodule

// File: rtl/jam_cost_loader.sv
// jam_cost_loader: buffers an 8x8 cost matrix for the JAM engine.
// Define JAM_COST_DBUF_EN for a second bank that loads while serving.
module jam_cost_loader
  import jam_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  jam_cost_loader_if.slave s_in,
  input  logic [IDX_W-1:0] W,
  input  logic [IDX_W-1:0] J,
  output cost_t            Cost,
  output logic             tbl_valid,
  input  logic             eng_done,
  output logic             err,
  output logic [7:0]       frame_cnt
);

  ld_state_e        r_state;
  logic [ENT_W-1:0] r_cnt;
  logic             r_tbl_valid;
  logic             r_err;
  logic             r_eng_done_q;
  logic [7:0]       r_frame_cnt;

  logic  w_ready;
  logic  w_xfer;
  logic  w_at_end;
  logic  w_good;
  logic  w_bad;
  logic  w_done_evt;
  cost_t w_rd;

  assign s_in.in_ready = w_ready;

  assign w_xfer     = s_in.in_valid && w_ready;
  assign w_at_end   = (r_cnt == LAST_ENT);
  assign w_good     = w_xfer && w_at_end && s_in.in_last;
  assign w_bad      = w_xfer && (w_at_end ^ s_in.in_last);
  assign w_done_evt = eng_done && !r_eng_done_q;

`ifdef JAM_COST_DBUF_EN

  logic  r_rd_bank;
  logic  r_pend;
  logic  r_regap;
  logic  w_wr_bank;
  logic  w_serving;
  logic  w_pend_n;
  cost_t w_rd0;
  cost_t w_rd1;

  assign w_wr_bank = ~r_rd_bank;
  assign w_ready   = !r_pend;
  assign w_serving = (r_state == SERVE);
  assign w_pend_n  = r_pend || (w_good && w_serving);
  assign w_rd      = r_rd_bank ? w_rd1 : w_rd0;

  jam_cost_bank u_bank0 (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (w_xfer && !w_wr_bank),
    .waddr (r_cnt),
    .wdata (s_in.in_data),
    .W     (W),
    .J     (J),
    .rdata (w_rd0)
  );

  jam_cost_bank u_bank1 (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (w_xfer && w_wr_bank),
    .waddr (r_cnt),
    .wdata (s_in.in_data),
    .W     (W),
    .J     (J),
    .rdata (w_rd1)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= LOAD;
      r_cnt        <= '0;
      r_tbl_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_eng_done_q <= 1'b0;
      r_frame_cnt  <= '0;
      r_rd_bank    <= 1'b0;
      r_pend       <= 1'b0;
      r_regap      <= 1'b0;
    end else begin
      r_eng_done_q <= eng_done;
      r_err        <= 1'b0;
      r_regap      <= 1'b0;
      if (r_regap) begin
        r_tbl_valid <= 1'b1;
      end
      if (w_xfer) begin
        unique case (1'b1)
          w_good: begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_cnt       <= '0;
          end
          w_bad: begin
            r_err <= 1'b1;
            r_cnt <= '0;
          end
          default: r_cnt <= r_cnt + 1'b1;
        endcase
      end
      // Swap gives a one-cycle tbl_valid gap so the engine re-arms.
      if (w_serving && w_done_evt) begin
        r_pend      <= 1'b0;
        r_tbl_valid <= 1'b0;
        if (w_pend_n) begin
          r_rd_bank <= ~r_rd_bank;
          r_regap   <= 1'b1;
        end else begin
          r_state <= LOAD;
        end
      end else if (w_good && !w_serving) begin
        r_rd_bank   <= ~r_rd_bank;
        r_tbl_valid <= 1'b1;
        r_state     <= SERVE;
      end else begin
        r_pend <= w_pend_n;
      end
    end
  end

`else

  assign w_ready = (r_state == LOAD);

  jam_cost_bank u_bank (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (w_xfer),
    .waddr (r_cnt),
    .wdata (s_in.in_data),
    .W     (W),
    .J     (J),
    .rdata (w_rd)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= LOAD;
      r_cnt        <= '0;
      r_tbl_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_eng_done_q <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_eng_done_q <= eng_done;
      r_err        <= 1'b0;
      unique case (r_state)
        LOAD: begin
          if (w_xfer) begin
            unique case (1'b1)
              w_good: begin
                r_state     <= SERVE;
                r_tbl_valid <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_cnt       <= '0;
              end
              w_bad: begin
                r_err <= 1'b1;
                r_cnt <= '0;
              end
              default: r_cnt <= r_cnt + 1'b1;
            endcase
          end
        end
        SERVE: begin
          if (w_done_evt) begin
            r_state     <= LOAD;
            r_tbl_valid <= 1'b0;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

`endif

  assign Cost      = r_tbl_valid ? w_rd : '0;
  assign tbl_valid = r_tbl_valid;
  assign err       = r_err;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_jam_cost_loader.sv
// tb_jam_cost_loader: directed checks of the single-bank loader.
// Drives on negedge, samples registered outputs on negedge.
module tb_jam_cost_loader;
  import jam_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IDX_W-1:0] W;
  logic [IDX_W-1:0] J;
  cost_t            cost;
  logic             tbl_valid;
  logic             eng_done;
  logic             err;
  logic [7:0]       frame_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  jam_cost_loader_if bus ();

  jam_cost_loader dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .s_in      (bus),
    .W         (W),
    .J         (J),
    .Cost      (cost),
    .tbl_valid (tbl_valid),
    .eng_done  (eng_done),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic cost_t pat(input int sel, input int k);
    int v;
    case (sel)
      1:       v = (k + 37) % 100;
      2:       v = (k * 5) % 100;
      3:       v = (k + 1) % 100;
      default: v = k % 100;
    endcase
    return cost_t'(v);
  endfunction

  task automatic send(input int sel, input int n, input int last_at,
                      input bit gap, output int ready_lo);
    ready_lo = 0;
    for (int k = 0; k < n; k++) begin
      if (gap) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = pat(sel, k);
      bus.in_last  = (k == last_at);
      #1;
      if (!bus.in_ready) ready_lo++;
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic rd(input int w, input int j, output int c);
    W = IDX_W'(w);
    J = IDX_W'(j);
    #1;
    c = int'(cost);
  endtask

  task automatic sweep(input int sel, output int bad);
    int c;
    bad = 0;
    for (int w = 0; w < N; w++) begin
      for (int j = 0; j < N; j++) begin
        rd(w, j, c);
        if (c != int'(pat(sel, w*8 + j))) bad++;
      end
    end
  endtask

  task automatic release_tbl();
    @(negedge clk);
    eng_done = 1'b1;
    repeat (3) @(negedge clk);
    eng_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lo, c, rises, rdy, errs;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    eng_done     = 1'b0;
    W            = '0;
    J            = '0;
    repeat (2) @(negedge clk);
    chk("rst_tbl_valid", int'(tbl_valid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    rd(3, 5, c);
    chk("rst_cost", c, 0);
    rst_n = 1'b1;

    send(0, 64, 63, 1'b0, lo);
    chk("A_ready_low", lo, 0);
    chk("A_tbl_valid", int'(tbl_valid), 1);
    chk("A_frame_cnt", int'(frame_cnt), 1);
    chk("A_in_ready", int'(bus.in_ready), 0);
    rd(3, 5, c);
    chk("A_cost_3_5", c, 29);
    rd(7, 7, c);
    chk("A_cost_7_7", c, 63);
    sweep(0, errs);
    chk("A_sweep", errs, 0);

    @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk);
    chk("done_tbl_valid", int'(tbl_valid), 0);
    chk("done_in_ready", int'(bus.in_ready), 1);
    rises = 0;
    repeat (9) begin
      @(negedge clk);
      if (tbl_valid || !bus.in_ready) rises++;
    end
    chk("done_no_retrig", rises, 0);
    rd(3, 5, c);
    chk("done_cost_zero", c, 0);
    eng_done = 1'b0;

    send(1, 64, 63, 1'b1, lo);
    chk("B_ready_low", lo, 0);
    chk("B_tbl_valid", int'(tbl_valid), 1);
    chk("B_frame_cnt", int'(frame_cnt), 2);
    rdy  = 0;
    errs = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = cost_t'(k);
      bus.in_last  = 1'b1;
      #1;
      if (bus.in_ready) rdy++;
      if (err) errs++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("serve_ready_high", rdy, 0);
    chk("serve_err", errs + int'(err), 0);
    chk("serve_frame_cnt", int'(frame_cnt), 2);
    sweep(1, errs);
    chk("B_sweep", errs, 0);

    release_tbl();
    send(0, 41, 40, 1'b0, lo);
    chk("short_err", int'(err), 1);
    chk("short_tbl_valid", int'(tbl_valid), 0);
    chk("short_frame_cnt", int'(frame_cnt), 2);
    @(negedge clk);
    chk("short_err_pulse", int'(err), 0);

    send(2, 64, 63, 1'b0, lo);
    chk("C_frame_cnt", int'(frame_cnt), 3);
    chk("C_tbl_valid", int'(tbl_valid), 1);
    rd(3, 5, c);
    chk("C_cost_3_5", c, 45);
    rd(7, 7, c);
    chk("C_cost_7_7", c, 15);

    release_tbl();
    send(0, 64, -1, 1'b0, lo);
    chk("nolast_err", int'(err), 1);
    chk("nolast_tbl_valid", int'(tbl_valid), 0);
    chk("nolast_frame_cnt", int'(frame_cnt), 3);
    chk("nolast_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    chk("nolast_err_pulse", int'(err), 0);

    send(0, 20, -1, 1'b0, lo);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_frame_cnt", int'(frame_cnt), 0);
    chk("mrst_tbl_valid", int'(tbl_valid), 0);
    chk("mrst_err", int'(err), 0);
    chk("mrst_in_ready", int'(bus.in_ready), 1);
    rst_n = 1'b1;
    rd(2, 3, c);
    chk("mrst_cost", c, 0);

    send(3, 64, 63, 1'b0, lo);
    chk("D_frame_cnt", int'(frame_cnt), 1);
    chk("D_tbl_valid", int'(tbl_valid), 1);
    rd(0, 0, c);
    chk("D_cost_0_0", c, 1);
    rd(2, 3, c);
    chk("D_cost_2_3", c, 20);
    sweep(3, errs);
    chk("D_sweep", errs, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
